// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: command codes, FSM encoding and widths
// shared by the program loader and its word assembler.
package prog_loader_pkg;

  localparam logic [7:0] CMD_LOAD_IM = 8'h01;
  localparam logic [7:0] CMD_LOAD_DM = 8'h02;
  localparam logic [7:0] CMD_RUN     = 8'h03;

  localparam int IDX_W = 2;

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts stream bytes big-endian into a
// 32-bit word; full_o flags that the next byte completes it.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      word_o <= '0;
      idx_q  <= '0;
    end else if (shift_i) begin
      word_o <= {word_o[23:0], byte_i};
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

  assign full_o = &idx_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream frame parser that writes CPU
// instruction/data memories, then releases the CPU on RUN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        im_we_o,
  output logic [7:0]  im_addr_o,
  output logic        dm_we_o,
  output logic [4:0]  dm_addr_o,
  output logic [31:0] wr_data_o,
  output logic        cpu_start_o,
  output logic        err_o
);

  localparam logic [8:0] IM_LIM = 9'(IM_DEPTH);
  localparam logic [8:0] DM_LIM = 9'(DM_DEPTH);

  state_t      state_q;
  state_t      state_d;
  logic        tgt_dm_q;
  logic [7:0]  addr_q;
  logic [7:0]  cnt_q;
  logic [7:0]  im_addr_q;
  logic [4:0]  dm_addr_q;
  logic        acc;
  logic        full;
  logic        clr;
  logic        shift;
  logic [8:0]  end_addr;
  logic [8:0]  lim;
  logic [31:0] word;

  assign acc      = in_valid_i && in_ready_o;
  assign shift    = acc && (state_q == ST_DATA);
  assign end_addr = {1'b0, addr_q} + {1'b0, in_data_i};
  assign lim      = tgt_dm_q ? DM_LIM : IM_LIM;
  assign clr      = (state_q == ST_COUNT) &&
                    (state_d == ST_DATA);

  word_assembler u_asm (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr),
    .shift_i (shift),
    .byte_i  (in_data_i),
    .word_o  (word),
    .full_o  (full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_CMD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CMD: begin
        if (acc) begin
          unique case (1'b1)
            (in_data_i == CMD_LOAD_IM),
            (in_data_i == CMD_LOAD_DM): state_d = ST_ADDR;
            (in_data_i == CMD_RUN):     state_d = ST_DONE;
            default:                    state_d = ST_ERR;
          endcase
        end
      end
      ST_ADDR: if (acc) state_d = ST_COUNT;
      ST_COUNT: begin
        if (acc) begin
          if (in_data_i == 8'd0 || end_addr > lim)
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: if (acc && full) state_d = ST_WRITE;
      ST_WRITE: begin
        if (cnt_q == 8'd1) state_d = ST_CMD;
        else               state_d = ST_DATA;
      end
      default: state_d = state_q;
    endcase
  end

  // Address outputs latch only for the target memory.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tgt_dm_q  <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      im_addr_q <= '0;
      dm_addr_q <= '0;
    end else begin
      if (acc && state_q == ST_CMD)
        tgt_dm_q <= (in_data_i == CMD_LOAD_DM);
      if (acc && state_q == ST_ADDR)
        addr_q <= in_data_i;
      if (acc && state_q == ST_COUNT)
        cnt_q <= in_data_i;
      if (shift && full) begin
        if (tgt_dm_q) dm_addr_q <= addr_q[4:0];
        else          im_addr_q <= addr_q;
      end
      if (state_q == ST_WRITE) begin
        addr_q <= addr_q + 8'd1;
        cnt_q  <= cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    in_ready_o  = 1'b0;
    im_we_o     = 1'b0;
    dm_we_o     = 1'b0;
    cpu_start_o = 1'b0;
    err_o       = 1'b0;
    unique case (state_q)
      ST_CMD, ST_ADDR, ST_COUNT, ST_DATA:
        in_ready_o = !rst_i;
      ST_WRITE: begin
        im_we_o = !rst_i && !tgt_dm_q;
        dm_we_o = !rst_i && tgt_dm_q;
      end
      ST_DONE: cpu_start_o = 1'b1;
      ST_ERR:  err_o       = 1'b1;
      default: ;
    endcase
  end

  assign im_addr_o = im_addr_q;
  assign dm_addr_o = dm_addr_q;
  assign wr_data_o = word;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: cycle vector table for an IM load plus
// directed frame sequences for DM, error, reset and RUN.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        vld = 1'b0;
  logic        rdy;
  logic        imwe;
  logic [7:0]  ia;
  logic        dmwe;
  logic [4:0]  da;
  logic [31:0] wd;
  logic        st;
  logic        er;

  int checks = 0;
  int fails  = 0;
  int hs     = 0;
  int rviol  = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (din),
    .in_valid_i  (vld),
    .in_ready_o  (rdy),
    .im_we_o     (imwe),
    .im_addr_o   (ia),
    .dm_we_o     (dmwe),
    .dm_addr_o   (da),
    .wr_data_o   (wd),
    .cpu_start_o (st),
    .err_o       (er)
  );

  typedef struct packed {
    logic        dm;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        imwe;
    logic [7:0]  ia;
    logic [31:0] wd;
    logic        st;
    logic        er;
  } vec_t;

  wr_t  wq[$];
  wr_t  ex[$];
  vec_t tv[16];

  always @(negedge clk) begin
    if (imwe) wq.push_back({1'b0, ia, wd});
    if (dmwe) wq.push_back({1'b1, {3'b000, da}, wd});
    if ((imwe || dmwe) && rdy) rviol++;
    if (vld && rdy) hs++;
  end

  function automatic wr_t mk(input logic dm,
                             input logic [7:0] a,
                             input logic [31:0] d);
    return {dm, a, d};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_wr(input string nm);
    chk({nm, "_count"}, 64'(wq.size()), 64'(ex.size()));
    foreach (ex[i])
      chk($sformatf("%s_w%0d", nm, i),
          64'((i < wq.size()) ? wq[i] : '0),
          64'(ex[i]));
    wq.delete();
    ex.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    vld = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit rnd);
    bit got;
    got = 1'b0;
    din = b;
    for (int n = 0; n < 400 && !got; n++) begin
      vld = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (vld && rdy) got = 1'b1;
      step();
    end
    vld = 1'b0;
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL send_%h got=no_handshake want=handshake", b);
    end
  endtask

  task automatic send_seq(input logic [7:0] s[$], input bit rnd);
    foreach (s[i]) send(s[i], rnd);
  endtask

  initial begin
    logic [63:0] act;
    logic [63:0] exp;
    int bad;
    int hs0;

    tv[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 32'h0, 0, 0};
    tv[1]  = '{0, 1, 8'h01, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[2]  = '{0, 1, 8'h00, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[3]  = '{0, 1, 8'h02, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[4]  = '{0, 1, 8'h20, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[5]  = '{0, 1, 8'h01, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[6]  = '{0, 1, 8'h00, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[7]  = '{0, 1, 8'h0A, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[8]  = '{0, 1, 8'h8C, 0, 1, 8'h00, 32'h2001000A, 0, 0};
    tv[9]  = '{0, 1, 8'h8C, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[10] = '{0, 1, 8'h02, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[11] = '{0, 1, 8'h00, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[12] = '{0, 1, 8'h00, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[13] = '{0, 1, 8'h03, 0, 1, 8'h01, 32'h8C020000, 0, 0};
    tv[14] = '{0, 1, 8'h03, 1, 0, 8'h00, 32'h0, 0, 0};
    tv[15] = '{0, 0, 8'h00, 0, 0, 8'h00, 32'h0, 1, 0};

    step();
    foreach (tv[i]) begin
      rst = tv[i].rst;
      vld = tv[i].vld;
      din = tv[i].d;
      @(negedge clk);
      act = {19'd0, rdy, imwe, dmwe, st, er,
             tv[i].imwe ? ia : 8'h00,
             tv[i].imwe ? wd : 32'h0};
      exp = {19'd0, tv[i].rdy, tv[i].imwe, 1'b0,
             tv[i].st, tv[i].er, tv[i].ia, tv[i].wd};
      chk($sformatf("vec%0d", i), act, exp);
      step();
    end
    vld = 1'b0;

    do_reset();
    wq.delete();
    send_seq('{8'h02, 8'h1F, 8'h01,
               8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
    idle(2);
    ex.push_back(mk(1'b1, 8'd31, 32'hDEADBEEF));
    chk_wr("dm_last");
    send_seq('{8'h02, 8'h1F, 8'h02}, 1'b0);
    chk("dm_range_err", 64'(er), 64'(1));
    chk("dm_range_rdy", 64'(rdy), 64'(0));
    idle(2);
    chk_wr("dm_range_nowr");

    do_reset();
    send(8'h05, 1'b0);
    chk("badcmd_err", 64'(er), 64'(1));
    chk("badcmd_rdy", 64'(rdy), 64'(0));
    bad = 0;
    hs0 = hs;
    vld = 1'b1;
    din = 8'h01;
    repeat (20) begin
      @(negedge clk);
      if (!er || rdy) bad++;
      step();
    end
    vld = 1'b0;
    chk("badcmd_hold", 64'(bad), 64'(0));
    chk("badcmd_nohs", 64'(hs - hs0), 64'(0));
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_err", 64'(er), 64'(0));
    chk("rst_rdy", 64'(rdy), 64'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(rdy), 64'(1));
    step();

    do_reset();
    wq.delete();
    rviol = 0;
    send_seq('{8'h01, 8'h10, 8'h03,
               8'h11, 8'h22, 8'h33, 8'h44,
               8'hA5, 8'hA5, 8'hA5, 8'hA5,
               8'h0F, 8'h0E, 8'h0D, 8'h0C}, 1'b1);
    idle(3);
    ex.push_back(mk(1'b0, 8'h10, 32'h11223344));
    ex.push_back(mk(1'b0, 8'h11, 32'hA5A5A5A5));
    ex.push_back(mk(1'b0, 8'h12, 32'h0F0E0D0C));
    chk_wr("im_rand");
    chk("im_rand_rdy_write", 64'(rviol), 64'(0));
    chk("im_rand_noerr", 64'(er), 64'(0));

    do_reset();
    wq.delete();
    send_seq('{8'h02, 8'h05, 8'h01, 8'hAA, 8'hBB}, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(6);
    chk_wr("abort_nowr");
    chk("abort_start", 64'(st), 64'(0));
    send_seq('{8'h02, 8'h05, 8'h01,
               8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
    idle(2);
    ex.push_back(mk(1'b1, 8'd5, 32'h11223344));
    chk_wr("fresh_dm");

    send(8'h03, 1'b0);
    chk("run_start", 64'(st), 64'(1));
    chk("run_noerr", 64'(er), 64'(0));
    hs0 = hs;
    vld = 1'b1;
    din = 8'h01;
    repeat (10) step();
    vld = 1'b0;
    idle(2);
    chk("run_nohs", 64'(hs - hs0), 64'(0));
    chk_wr("run_nowr");
    chk("run_sticky", 64'(st), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
